// File: rtl/hpm_event_tap.sv
// Front end of the HPM counter peripheral: turns bus handshakes and retire
// strobes into single-cycle event pulses, tracking reads in order until they return.
module hpm_event_tap #(
  parameter int                 ADDR_W      = 32,
  parameter int                 MAX_OUTST   = 4,
  parameter logic [ADDR_W-1:0]  FILTER_BASE = '0,
  parameter logic [ADDR_W-1:0]  FILTER_MASK = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           filter_en,
  input  logic                           err_clr,
  input  logic                           bus_req_valid,
  input  logic                           bus_req_ready,
  input  logic                           bus_req_we,
  input  logic [ADDR_W-1:0]              bus_req_addr,
  input  logic                           bus_rsp_valid,
  input  logic                           ret_valid,
  output logic                           cpu_retired_inst,
  output logic                           cpu_mem_rd,
  output logic                           cpu_mem_wr,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
  output logic                           err_sticky
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);

  // Handshake: a request transfers on any rising edge where bus_req_valid and
  // bus_req_ready are both high; bus_rsp_valid is a one-cycle, in-order read return.
  typedef enum logic [1:0] {
    TRK_EMPTY = 2'd0,
    TRK_BUSY  = 2'd1,
    TRK_FULL  = 2'd2
  } trk_state_e;

  trk_state_e       trk_state, trk_state_next;
  logic [CNT_W-1:0] cnt_next;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             tag_mem [MAX_OUTST];

  logic accept, rd_acc, wr_acc, match;
  logic push, pop, overflow, underflow;

  assign accept = bus_req_valid & bus_req_ready;
  assign rd_acc = accept & ~bus_req_we;
  assign wr_acc = accept & bus_req_we;
  assign match  = ~filter_en | ((bus_req_addr & FILTER_MASK) == (FILTER_BASE & FILTER_MASK));

  always_comb begin
    pop            = 1'b0;
    push           = 1'b0;
    overflow       = 1'b0;
    underflow      = 1'b0;
    cnt_next       = outst_cnt;
    trk_state_next = trk_state;

    pop       = bus_rsp_valid & (trk_state != TRK_EMPTY);
    underflow = bus_rsp_valid & (trk_state == TRK_EMPTY);
    // A full tracker can still take a read if the head retires in the same cycle.
    push      = rd_acc & ((trk_state != TRK_FULL) | pop);
    overflow  = rd_acc & (trk_state == TRK_FULL) & ~pop;

    if (push && !pop)      cnt_next = outst_cnt + CNT_W'(1);
    else if (pop && !push) cnt_next = outst_cnt - CNT_W'(1);

    if (cnt_next == '0)           trk_state_next = TRK_EMPTY;
    else if (cnt_next == CNT_FULL) trk_state_next = TRK_FULL;
    else                           trk_state_next = TRK_BUSY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_state <= TRK_EMPTY;
      outst_cnt <= '0;
    end else begin
      trk_state <= trk_state_next;
      outst_cnt <= cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < MAX_OUTST; i++) tag_mem[i] <= 1'b0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= match;
        wr_ptr          <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
    end
  end

  // The head tag is read before the edge, so a push into the same slot when full is safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_retired_inst <= 1'b0;
      cpu_mem_rd       <= 1'b0;
      cpu_mem_wr       <= 1'b0;
      err_sticky       <= 1'b0;
    end else begin
      cpu_retired_inst <= ret_valid;
      cpu_mem_rd       <= pop & tag_mem[rd_ptr];
      cpu_mem_wr       <= wr_acc & match;
      if (overflow || underflow) err_sticky <= 1'b1;
      else if (err_clr)          err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hpm_event_tap.sv
// Directed bench for hpm_event_tap with a 0x4xxx_xxxx address window and 4-deep tracker.
module tb_hpm_event_tap;

  localparam int ADDR_W = 32;
  localparam int MAX_OUTST = 4;
  localparam logic [31:0] IN_ADDR  = 32'h4000_0010;
  localparam logic [31:0] OUT_ADDR = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        filter_en, err_clr;
  logic        bus_req_valid, bus_req_ready, bus_req_we;
  logic [31:0] bus_req_addr;
  logic        bus_rsp_valid, ret_valid;
  logic        cpu_retired_inst, cpu_mem_rd, cpu_mem_wr, err_sticky;
  logic [2:0]  outst_cnt;

  int n_vec = 0;
  int n_err = 0;

  hpm_event_tap #(
    .ADDR_W(ADDR_W), .MAX_OUTST(MAX_OUTST),
    .FILTER_BASE(32'h4000_0000), .FILTER_MASK(32'hF000_0000)
  ) dut (
    .clk(clk), .rst(rst), .filter_en(filter_en), .err_clr(err_clr),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
    .bus_rsp_valid(bus_rsp_valid), .ret_valid(ret_valid),
    .cpu_retired_inst(cpu_retired_inst), .cpu_mem_rd(cpu_mem_rd),
    .cpu_mem_wr(cpu_mem_wr), .outst_cnt(outst_cnt), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // Drivers: set inputs, then tick() clocks once and settles 1ns past the edge.
  task automatic idle();
    bus_req_valid = 1'b0; bus_req_ready = 1'b1; bus_req_we = 1'b0;
    bus_req_addr = '0; bus_rsp_valid = 1'b0; ret_valid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr);
    bus_req_valid = 1'b1; bus_req_we = we; bus_req_addr = addr;
  endtask

  task automatic test_reset();
    rst = 1'b1; filter_en = 1'b0; idle();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (cpu_retired_inst !== 1'b0) begin n_err++; $display("FAIL reset_ret: got %b want 0", cpu_retired_inst); end
    n_vec++; if (cpu_mem_rd !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %b want 0", cpu_mem_rd); end
    n_vec++; if (cpu_mem_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr: got %b want 0", cpu_mem_wr); end
    n_vec++; if (outst_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", outst_cnt); end
    n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_sticky); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_retire();
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      ret_valid = 1'b1;
      tick();
      n_vec++; if (cpu_retired_inst !== 1'b1) begin n_err++; $display("FAIL retire_%0d: got %b want 1", i, cpu_retired_inst); end
      if (cpu_retired_inst === 1'b1) pulses++;
    end
    tick();
    n_vec++; if (cpu_retired_inst !== 1'b0) begin n_err++; $display("FAIL retire_end: got %b want 0", cpu_retired_inst); end
    n_vec++; if (pulses != 5) begin n_err++; $display("FAIL retire_count: got %0d want 5", pulses); end
  endtask

  task automatic test_write_filter();
    logic [31:0] addrs [2];
    logic        exp_f [2];
    addrs[0] = IN_ADDR; addrs[1] = OUT_ADDR;
    exp_f[0] = 1'b1;    exp_f[1] = 1'b0;
    for (int f = 1; f >= 0; f--) begin
      filter_en = f[0];
      for (int i = 0; i < 2; i++) begin
        drive_req(1'b1, addrs[i]);
        tick();
        n_vec++;
        if (cpu_mem_wr !== (f == 1 ? exp_f[i] : 1'b1)) begin
          n_err++; $display("FAIL wr_f%0d_%0d: got %b want %b", f, i, cpu_mem_wr, (f == 1 ? exp_f[i] : 1'b1));
        end
        n_vec++; if (outst_cnt !== 3'd0) begin n_err++; $display("FAIL wr_cnt_f%0d_%0d: got %0d want 0", f, i, outst_cnt); end
      end
      tick();
      n_vec++; if (cpu_mem_wr !== 1'b0) begin n_err++; $display("FAIL wr_idle_f%0d: got %b want 0", f, cpu_mem_wr); end
    end
  endtask

  task automatic test_pipelined_reads();
    filter_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b0, 32'h100 + 32'(i * 4));
      tick();
      n_vec++; if (outst_cnt !== 3'(i + 1)) begin n_err++; $display("FAIL pipe_cnt_%0d: got %0d want %0d", i, outst_cnt, i + 1); end
      n_vec++; if (cpu_mem_rd !== 1'b0) begin n_err++; $display("FAIL pipe_rd_early_%0d: got %b want 0", i, cpu_mem_rd); end
    end
    n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL pipe_err_pre: got %b want 0", err_sticky); end
    drive_req(1'b0, 32'h200);
    tick();
    n_vec++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL overflow_err: got %b want 1", err_sticky); end
    n_vec++; if (outst_cnt !== 3'd4) begin n_err++; $display("FAIL overflow_cnt: got %0d want 4", outst_cnt); end
    err_clr = 1'b1;
    tick();
    n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL err_clr: got %b want 0", err_sticky); end
    for (int i = 0; i < 4; i++) begin
      bus_rsp_valid = 1'b1;
      tick();
      n_vec++; if (cpu_mem_rd !== 1'b1) begin n_err++; $display("FAIL pipe_rd_%0d: got %b want 1", i, cpu_mem_rd); end
      n_vec++; if (outst_cnt !== 3'(3 - i)) begin n_err++; $display("FAIL pipe_drain_cnt_%0d: got %0d want %0d", i, outst_cnt, 3 - i); end
    end
    tick();
    n_vec++; if (cpu_mem_rd !== 1'b0) begin n_err++; $display("FAIL pipe_rd_idle: got %b want 0", cpu_mem_rd); end
    n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL pipe_err_post: got %b want 0", err_sticky); end
  endtask

  task automatic test_tag_order();
    logic [31:0] addrs [3];
    logic        exp_rd [3];
    addrs[0] = IN_ADDR; addrs[1] = OUT_ADDR; addrs[2] = 32'h4000_0004;
    exp_rd[0] = 1'b1;   exp_rd[1] = 1'b0;    exp_rd[2] = 1'b1;
    filter_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b0, addrs[i]);
      tick();
    end
    filter_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_rsp_valid = 1'b1;
      tick();
      n_vec++; if (cpu_mem_rd !== exp_rd[i]) begin n_err++; $display("FAIL tag_order_%0d: got %b want %b", i, cpu_mem_rd, exp_rd[i]); end
    end
    n_vec++; if (outst_cnt !== 3'd0) begin n_err++; $display("FAIL tag_cnt: got %0d want 0", outst_cnt); end
  endtask

  task automatic test_back_to_back();
    logic exp_rd [4];
    exp_rd[0] = 1'b1; exp_rd[1] = 1'b1; exp_rd[2] = 1'b1; exp_rd[3] = 1'b0;
    filter_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b0, IN_ADDR);
      tick();
    end
    // Full tracker: accept an out-of-window read while the head returns.
    filter_en = 1'b1;
    drive_req(1'b0, OUT_ADDR);
    bus_rsp_valid = 1'b1;
    tick();
    n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL full_simul_err: got %b want 0", err_sticky); end
    n_vec++; if (outst_cnt !== 3'd4) begin n_err++; $display("FAIL full_simul_cnt: got %0d want 4", outst_cnt); end
    n_vec++; if (cpu_mem_rd !== 1'b1) begin n_err++; $display("FAIL full_simul_rd: got %b want 1", cpu_mem_rd); end
    for (int i = 0; i < 4; i++) begin
      bus_rsp_valid = 1'b1;
      tick();
      n_vec++; if (cpu_mem_rd !== exp_rd[i]) begin n_err++; $display("FAIL full_drain_%0d: got %b want %b", i, cpu_mem_rd, exp_rd[i]); end
    end
    n_vec++; if (outst_cnt !== 3'd0) begin n_err++; $display("FAIL full_drain_cnt: got %0d want 0", outst_cnt); end
    bus_rsp_valid = 1'b1;
    tick();
    n_vec++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL underflow_err: got %b want 1", err_sticky); end
    n_vec++; if (cpu_mem_rd !== 1'b0) begin n_err++; $display("FAIL underflow_rd: got %b want 0", cpu_mem_rd); end
    n_vec++; if (outst_cnt !== 3'd0) begin n_err++; $display("FAIL underflow_cnt: got %0d want 0", outst_cnt); end
    err_clr = 1'b1; bus_rsp_valid = 1'b1;
    tick();
    n_vec++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL set_beats_clr: got %b want 1", err_sticky); end
    err_clr = 1'b1;
    tick();
    n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL clr_after: got %b want 0", err_sticky); end
    // Empty tracker: read accept and response together -> error, push still happens.
    filter_en = 1'b1;
    drive_req(1'b0, IN_ADDR);
    bus_rsp_valid = 1'b1;
    tick();
    n_vec++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL empty_simul_err: got %b want 1", err_sticky); end
    n_vec++; if (cpu_mem_rd !== 1'b0) begin n_err++; $display("FAIL empty_simul_rd: got %b want 0", cpu_mem_rd); end
    n_vec++; if (outst_cnt !== 3'd1) begin n_err++; $display("FAIL empty_simul_cnt: got %0d want 1", outst_cnt); end
    err_clr = 1'b1; bus_rsp_valid = 1'b1;
    tick();
    n_vec++; if (cpu_mem_rd !== 1'b1) begin n_err++; $display("FAIL empty_simul_pop: got %b want 1", cpu_mem_rd); end
    n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL empty_simul_clr: got %b want 0", err_sticky); end
    n_vec++; if (outst_cnt !== 3'd0) begin n_err++; $display("FAIL empty_simul_cnt2: got %0d want 0", outst_cnt); end
  endtask

  task automatic test_reset_mid();
    filter_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_req(1'b0, IN_ADDR);
      ret_valid = 1'b1;
      tick();
    end
    n_vec++; if (outst_cnt !== 3'd2) begin n_err++; $display("FAIL mid_cnt_pre: got %0d want 2", outst_cnt); end
    rst = 1'b1;
    #1;
    n_vec++; if (outst_cnt !== 3'd0) begin n_err++; $display("FAIL mid_async_cnt: got %0d want 0", outst_cnt); end
    n_vec++; if (cpu_retired_inst !== 1'b0) begin n_err++; $display("FAIL mid_async_ret: got %b want 0", cpu_retired_inst); end
    tick();
    rst = 1'b0;
    n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL mid_err_rst: got %b want 0", err_sticky); end
    bus_rsp_valid = 1'b1;
    tick();
    n_vec++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL mid_stale_err: got %b want 1", err_sticky); end
    n_vec++; if (cpu_mem_rd !== 1'b0) begin n_err++; $display("FAIL mid_stale_rd: got %b want 0", cpu_mem_rd); end
  endtask

  initial begin
    test_reset();
    test_retire();
    test_write_filter();
    test_pipelined_reads();
    test_tag_order();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
